// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and stall controller for the 5-stage pipeline.
//               Decides, every cycle, whether each stage register advances,
//               holds or loads a bubble. Handles load-use / RAW hazards,
//               taken-branch squashes and multi-cycle data-memory waits,
//               with a sticky watchdog error on memory timeout.
//               Optional build macro: HAZARD_FWD_EN (operand forwarding).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  // ID stage sources
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  // EX stage
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  // MEM stage
  input  logic [4:0]  mem_rd,
  input  logic        mem_RegWrite,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  // WB stage
  input  logic [4:0]  wb_rd,
  input  logic        wb_RegWrite,
  // Branch resolution and memory handshake
  input  logic        ex_branch_taken,
  input  logic        dmem_ready,
  // Stage-register controls
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        dmem_req,
  // Forwarding selects
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  // Status
  output logic [1:0]  state,
  output logic        err,
  output logic [31:0] stall_cycles
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERR      = 2'b10;

  // Forwarding select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Watchdog limit widened by one bit so the incremented count never wraps
  // before it is compared.
  localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [15:0] wait_cnt;
  logic [16:0] wait_next;
  logic        active;
  logic        mem_access;
  logic        mem_wait;
  logic        load_use;
  logic        raw_stall;

  // RUN and MEM_WAIT are the only states in which memory may be accessed;
  // an undefined encoding is treated like ERR (pipeline frozen).
  assign active     = (state == ST_RUN) || (state == ST_MEM_WAIT);
  assign mem_access = mem_MemRead | mem_MemWrite;

  // Outstanding memory access that does not complete this cycle. This is the
  // top-priority freeze condition.
  assign mem_wait   = ~rst & active & mem_access & ~dmem_ready;

  assign wait_next  = {1'b0, wait_cnt} + 17'd1;

  // Load in EX whose destination is read by the instruction in ID; r0 is
  // hard-wired to zero so it can never be a real dependency.
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef HAZARD_FWD_EN
  // With forwarding, only a load-use pair still has to stall: the loaded
  // value is not available until the end of MEM.
  assign raw_stall = load_use;

  // ex_RegWrite only matters for the non-forwarding RAW check.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ex_RegWrite;
`else
  // Without forwarding, any pending producer in EX or MEM must retire to WB
  // before the consumer in ID may proceed. WB itself does not stall because
  // the register file writes in the first half and reads in the second.
  logic ex_raw;
  logic mem_raw;

  assign ex_raw  = ex_RegWrite && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_raw = mem_RegWrite && (mem_rd != 5'd0) &&
                   ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  assign raw_stall = load_use | ex_raw | mem_raw;

  // Forwarding inputs are not consumed in this build.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_RegWrite};
`endif

  // --------------------------------------------------------------------------
  // Stage-register enable / flush decision, in priority order:
  //   reset > ERR > memory wait > taken branch > RAW stall > advance.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    if (rst) begin
      // Everything inert while in reset.
      memwb_bubble = 1'b0;
    end else if (!active) begin
      // Watchdog tripped: freeze the pipe and keep WB quiet.
      memwb_bubble = 1'b1;
    end else if (mem_wait) begin
      // Freeze every stage; a branch sitting in EX is held until resume.
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two younger instructions; the ID instruction is discarded
      // so any load-use match on it is irrelevant.
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (raw_stall) begin
      // Hold PC and IF/ID, inject a bubble into EX, let older stages drain.
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      idex_flush = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

  // Memory request qualifier: only meaningful while the controller is live.
  always_comb begin
    dmem_req = ~rst & active & mem_access;
  end

  // --------------------------------------------------------------------------
  // Operand forwarding selects (EX/MEM has priority over MEM/WB).
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`ifdef HAZARD_FWD_EN
    if (!rst) begin
      if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
        fwd_a = FWD_EXMEM;
      end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
        fwd_a = FWD_MEMWB;
      end

      if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_rt)) begin
        fwd_b = FWD_EXMEM;
      end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_rt)) begin
        fwd_b = FWD_MEMWB;
      end
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Control FSM with memory-wait watchdog; ERR is sticky until reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= 16'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_wait) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 16'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_wait) begin
            // Access completed (or withdrawn): resume normal flow.
            state    <= ST_RUN;
            wait_cnt <= 16'd0;
          end else if (wait_next == TIMEOUT_CNT) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            wait_cnt <= wait_next[15:0];
          end else begin
            wait_cnt <= wait_next[15:0];
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
          err   <= 1'b1;
        end
        default: begin
          // Undefined encoding: fail safe into the error state.
          state <= ST_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_RegWrite, ex_MemRead;
  logic [4:0]  mem_rd;
  logic        mem_RegWrite, mem_MemRead, mem_MemWrite;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        ex_branch_taken;
  logic        dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble, dmem_req;
  logic [1:0]  fwd_a, fwd_b;
  logic [1:0]  state;
  logic        err;
  logic [31:0] stall_cycles;

  int vectors;
  int miscompares;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, dmem_req}
  logic [7:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en,
                ifid_flush, idex_flush, memwb_bubble, dmem_req};

  localparam logic [7:0] CTL_RESET   = 8'b0000_0000;
  localparam logic [7:0] CTL_RUN     = 8'b1111_0000;
  localparam logic [7:0] CTL_RUN_REQ = 8'b1111_0001;
  localparam logic [7:0] CTL_STALL   = 8'b0011_0100;
  localparam logic [7:0] CTL_BRANCH  = 8'b1111_1100;
  localparam logic [7:0] CTL_MWAIT   = 8'b0000_0011;
  localparam logic [7:0] CTL_ERR     = 8'b0000_0010;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_RegWrite     (ex_RegWrite),
    .ex_MemRead      (ex_MemRead),
    .mem_rd          (mem_rd),
    .mem_RegWrite    (mem_RegWrite),
    .mem_MemRead     (mem_MemRead),
    .mem_MemWrite    (mem_MemWrite),
    .wb_rd           (wb_rd),
    .wb_RegWrite     (wb_RegWrite),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .dmem_req        (dmem_req),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .state           (state),
    .err             (err),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute run-time guard.
  initial begin
    #200000;
    $display("FAIL run_guard: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

  // One clock edge, then move 1 time unit past it before touching inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_RegWrite = 1'b0; ex_MemRead = 1'b0;
    mem_rd = 5'd0; mem_RegWrite = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    wb_rd = 5'd0; wb_RegWrite = 1'b0;
    ex_branch_taken = 1'b0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    mem_MemRead = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    mem_RegWrite = 1'b1; mem_rd = 5'd7; ex_rs = 5'd7; ex_rt = 5'd7;
    #1;
    vectors++;
    if (ctl !== CTL_RESET) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RESET);
    end
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b});
    end
    tick();
    vectors++;
    if ({state, err, stall_cycles} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_regs: state=%b err=%b stall=%0d expected 00/0/0",
               state, err, stall_cycles);
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== CTL_RUN) begin
      miscompares++;
      $display("FAIL idle_run: got %b expected %b", ctl, CTL_RUN);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_use();
    logic [7:0]  exp_second;
    logic [31:0] exp_stalls;
    do_reset();
    // r0 destination never stalls.
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    vectors++;
    if (ctl !== CTL_RUN) begin
      miscompares++;
      $display("FAIL load_use_r0: got %b expected %b", ctl, CTL_RUN);
    end
    // rt match ignored when the ID instruction does not read rt.
    ex_rd = 5'd6; id_rs = 5'd1; id_rt = 5'd6; id_uses_rt = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_RUN) begin
      miscompares++;
      $display("FAIL load_use_rt_unused: got %b expected %b", ctl, CTL_RUN);
    end
    id_uses_rt = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_STALL) begin
      miscompares++;
      $display("FAIL load_use_rt: got %b expected %b", ctl, CTL_STALL);
    end
    // Main case: load r5 in EX, ID reads r5 through rs.
    id_uses_rt = 1'b0; id_rt = 5'd2; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    vectors++;
    if (ctl !== CTL_STALL) begin
      miscompares++;
      $display("FAIL load_use_rs: got %b expected %b", ctl, CTL_STALL);
    end
    tick();
    // Load now in MEM, EX holds the bubble, memory answers at once.
    ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_rd = 5'd0;
    mem_MemRead = 1'b1; mem_RegWrite = 1'b1; mem_rd = 5'd5; dmem_ready = 1'b1;
`ifdef HAZARD_FWD_EN
    exp_second = CTL_RUN_REQ;
    exp_stalls = 32'd1;
`else
    exp_second = 8'b0011_0101;
    exp_stalls = 32'd2;
`endif
    #1;
    vectors++;
    if (ctl !== exp_second) begin
      miscompares++;
      $display("FAIL load_use_next: got %b expected %b", ctl, exp_second);
    end
    tick();
    vectors++;
    if (stall_cycles !== exp_stalls) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d expected %0d", stall_cycles, exp_stalls);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_branch();
    do_reset();
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    ex_branch_taken = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_BRANCH) begin
      miscompares++;
      $display("FAIL branch_over_load_use: got %b expected %b", ctl, CTL_BRANCH);
    end
    tick();
    vectors++;
    if (stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL branch_count: got %0d expected 0", stall_cycles);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mem_wait();
    do_reset();
    mem_MemWrite = 1'b1; dmem_ready = 1'b0;
    #1;
    vectors++;
    if ({state, ctl} !== {2'b00, CTL_MWAIT}) begin
      miscompares++;
      $display("FAIL mwait_c0: got state=%b ctl=%b expected 00/%b", state, ctl, CTL_MWAIT);
    end
    tick();
    ex_branch_taken = 1'b1;   // branch arrives while frozen: held
    #1;
    vectors++;
    if ({state, ctl} !== {2'b01, CTL_MWAIT}) begin
      miscompares++;
      $display("FAIL mwait_c1: got state=%b ctl=%b expected 01/%b", state, ctl, CTL_MWAIT);
    end
    tick();
    vectors++;
    if ({state, ctl} !== {2'b01, CTL_MWAIT}) begin
      miscompares++;
      $display("FAIL mwait_c2: got state=%b ctl=%b expected 01/%b", state, ctl, CTL_MWAIT);
    end
    tick();
    dmem_ready = 1'b1;        // completes: resume and act on the branch now
    #1;
    vectors++;
    if ({state, ctl} !== {2'b01, 8'b1111_1101}) begin
      miscompares++;
      $display("FAIL mwait_resume: got state=%b ctl=%b expected 01/11111101", state, ctl);
    end
    tick();
    vectors++;
    if ({state, stall_cycles} !== {2'b00, 32'd3}) begin
      miscompares++;
      $display("FAIL mwait_done: got state=%b stall=%0d expected 00/3", state, stall_cycles);
    end
    // Back-to-back access with memory ready: no added stall.
    ex_branch_taken = 1'b0;
    #1;
    vectors++;
    if (ctl !== CTL_RUN_REQ) begin
      miscompares++;
      $display("FAIL mem_ready_ctl: got %b expected %b", ctl, CTL_RUN_REQ);
    end
    tick();
    vectors++;
    if ({state, stall_cycles} !== {2'b00, 32'd3}) begin
      miscompares++;
      $display("FAIL mem_ready_count: got state=%b stall=%0d expected 00/3", state, stall_cycles);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timeout();
    do_reset();
    mem_MemRead = 1'b1; dmem_ready = 1'b0;
    tick();                   // RUN -> MEM_WAIT
    tick();
    tick();
    tick();                   // three wait cycles elapsed
    vectors++;
    if ({state, err} !== 3'b010) begin
      miscompares++;
      $display("FAIL timeout_pre: got state=%b err=%b expected 01/0", state, err);
    end
    tick();                   // fourth wait cycle -> ERR
    vectors++;
    if ({state, err, ctl} !== {2'b10, 1'b1, CTL_ERR}) begin
      miscompares++;
      $display("FAIL timeout_err: got state=%b err=%b ctl=%b expected 10/1/%b",
               state, err, ctl, CTL_ERR);
    end
    vectors++;
    if (stall_cycles !== 32'd5) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d expected 5", stall_cycles);
    end
    dmem_ready = 1'b1;
    tick();
    vectors++;
    if ({state, err, stall_cycles} !== {2'b10, 1'b1, 32'd6}) begin
      miscompares++;
      $display("FAIL err_sticky: got state=%b err=%b stall=%0d expected 10/1/6",
               state, err, stall_cycles);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ctl !== CTL_RESET) begin
      miscompares++;
      $display("FAIL err_rst_ctl: got %b expected %b", ctl, CTL_RESET);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if ({state, err, stall_cycles} !== 35'd0) begin
      miscompares++;
      $display("FAIL err_rst_regs: got state=%b err=%b stall=%0d expected 00/0/0",
               state, err, stall_cycles);
    end
    // Reset while waiting returns to RUN even with memory still busy.
    mem_MemRead = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (state !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got state=%b expected 00", state);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
`ifdef HAZARD_FWD_EN
  task automatic test_forwarding();
    do_reset();
    mem_RegWrite = 1'b1; wb_RegWrite = 1'b1;
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs = 5'd7; ex_rt = 5'd9;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b10_00) begin
      miscompares++;
      $display("FAIL fwd_exmem_prio: got %b expected 1000", {fwd_a, fwd_b});
    end
    mem_rd = 5'd8; ex_rt = 5'd8;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b01_10) begin
      miscompares++;
      $display("FAIL fwd_memwb: got %b expected 0110", {fwd_a, fwd_b});
    end
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b00_00) begin
      miscompares++;
      $display("FAIL fwd_r0: got %b expected 0000", {fwd_a, fwd_b});
    end
    // ALU producer in EX needs no stall when forwarding exists.
    ex_RegWrite = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
    #1;
    vectors++;
    if (ctl !== CTL_RUN) begin
      miscompares++;
      $display("FAIL fwd_no_stall: got %b expected %b", ctl, CTL_RUN);
    end
  endtask
`else
  task automatic test_raw_no_fwd();
    do_reset();
    mem_RegWrite = 1'b1; wb_RegWrite = 1'b1;
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs = 5'd7; ex_rt = 5'd7;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      miscompares++;
      $display("FAIL nofwd_fwd: got %b expected 0000", {fwd_a, fwd_b});
    end
    idle_inputs();
    ex_RegWrite = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
    #1;
    vectors++;
    if (ctl !== CTL_STALL) begin
      miscompares++;
      $display("FAIL nofwd_ex: got %b expected %b", ctl, CTL_STALL);
    end
    tick();
    ex_RegWrite = 1'b0; ex_rd = 5'd0;
    mem_RegWrite = 1'b1; mem_rd = 5'd3;
    #1;
    vectors++;
    if (ctl !== CTL_STALL) begin
      miscompares++;
      $display("FAIL nofwd_mem: got %b expected %b", ctl, CTL_STALL);
    end
    tick();
    mem_RegWrite = 1'b0; mem_rd = 5'd0;
    wb_RegWrite = 1'b1; wb_rd = 5'd3;
    #1;
    vectors++;
    if ({ctl, fwd_a} !== {CTL_RUN, 2'b00}) begin
      miscompares++;
      $display("FAIL nofwd_wb: got ctl=%b fwd_a=%b expected %b/00", ctl, fwd_a, CTL_RUN);
    end
    tick();
    vectors++;
    if (stall_cycles !== 32'd2) begin
      miscompares++;
      $display("FAIL nofwd_count: got %0d expected 2", stall_cycles);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_FWD_EN
    test_forwarding();
`else
    test_raw_no_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
